vproc_dispatcher_hazard: RTL



---
 rtl/vproc_dispatcher_hazard.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/vproc_dispatcher_hazard.sv
// Vector-core dispatcher: one-entry holding register, per-vreg pending-write counters,
// RAW/WAW hazard stall and rotating-priority issue to pipelines that support the unit.
package vproc_dispatcher_hazard_pkg;
    typedef struct packed {
        logic [2:0] unit;
        logic [7:0] op;
    } decoder_data_t;
endpackage

module vproc_dispatcher_hazard #(
    parameter int                              PIPE_CNT    = 2,
    parameter int                              UNIT_CNT    = 8,
    parameter logic [PIPE_CNT-1:0][UNIT_CNT-1:0] PIPE_UNITS = '0,
    parameter int                              MAX_VADDR_W = 5,
    parameter int                              CNT_W       = 2,
    parameter bit                              CHECK_RAW   = 1'b1,
    parameter bit                              ALLOW_WAW   = 1'b0,
    parameter type                             DECODER_DATA_T = vproc_dispatcher_hazard_pkg::decoder_data_t
) (
    input  logic                                          clk_i,
    input  logic                                          async_rst_ni,
    input  logic                                          instr_valid_i,
    output logic                                          instr_ready_o,
    input  DECODER_DATA_T                                 instr_data_i,
    input  logic [(1<<MAX_VADDR_W)-1:0]                   instr_vreg_wr_i,
    input  logic [(1<<MAX_VADDR_W)-1:0]                   instr_vreg_rd_i,
    output logic [PIPE_CNT-1:0]                           dispatch_valid_o,
    input  logic [PIPE_CNT-1:0]                           dispatch_ready_i,
    output DECODER_DATA_T                                 dispatch_data_o,
    output logic [(1<<MAX_VADDR_W)-1:0]                   pend_vreg_wr_map_o,
    input  logic [PIPE_CNT-1:0][(1<<MAX_VADDR_W)-1:0]     pend_vreg_wr_clear_i
);
    localparam int VADDR_CNT = 1 << MAX_VADDR_W;
    localparam int PTR_W     = (PIPE_CNT > 1) ? $clog2(PIPE_CNT) : 1;
    localparam int SUM_W     = CNT_W + $clog2(PIPE_CNT + 1);

    logic                                r_hold_valid;
    DECODER_DATA_T                       r_data;
    logic [VADDR_CNT-1:0]                r_wr;
    logic [VADDR_CNT-1:0]                r_rd;
    logic [VADDR_CNT-1:0][CNT_W-1:0]     r_cnt;
    logic [PTR_W-1:0]                    r_rr_ptr;
    logic                                r_locked;
    logic [PTR_W-1:0]                    r_sel;

    logic [VADDR_CNT-1:0]                w_pend;
    logic                                w_sat;
    logic                                w_stall;
    logic [PIPE_CNT-1:0]                 w_elig;
    logic                                w_found;
    logic [PTR_W-1:0]                    w_pick;
    logic [PTR_W-1:0]                    w_sel;
    logic                                w_go;
    logic                                w_issue;
    logic [VADDR_CNT-1:0][SUM_W-1:0]     w_sum;
    logic [VADDR_CNT-1:0][SUM_W-1:0]     w_clr;
    logic [VADDR_CNT-1:0][CNT_W-1:0]     w_cnt_d;

    always_comb begin
        w_sat = 1'b0;
        for (int v = 0; v < VADDR_CNT; v++) begin
            w_pend[v] = (r_cnt[v] != '0);
            if (r_wr[v] && (r_cnt[v] == {CNT_W{1'b1}}))
                w_sat = 1'b1;
        end
    end

    // A saturated counter cannot take another write, whatever the WAW policy.
    assign w_stall = (CHECK_RAW && (|(r_rd & w_pend)))
                   || (!ALLOW_WAW && (|(r_wr & w_pend)))
                   || w_sat;

    always_comb begin
        for (int p = 0; p < PIPE_CNT; p++)
            w_elig[p] = PIPE_UNITS[p][r_data.unit];
    end

    // First eligible pipe at or after the round-robin pointer, wrapping.
    always_comb begin
        w_found = 1'b0;
        w_pick  = r_rr_ptr;
        for (int i = 0; i < PIPE_CNT; i++) begin
            for (int p = 0; p < PIPE_CNT; p++) begin
                if (!w_found && w_elig[p] && (p == ((int'(r_rr_ptr) + i) % PIPE_CNT))) begin
                    w_found = 1'b1;
                    w_pick  = PTR_W'(p);
                end
            end
        end
    end

    assign w_sel = r_locked ? r_sel : w_pick;
    assign w_go  = r_hold_valid && !w_stall && (|w_elig);

    always_comb begin
        for (int p = 0; p < PIPE_CNT; p++)
            dispatch_valid_o[p] = w_go && (w_sel == PTR_W'(p));
    end

    assign w_issue            = |(dispatch_valid_o & dispatch_ready_i);
    assign instr_ready_o      = !r_hold_valid || w_issue;
    assign dispatch_data_o    = r_data;
    assign pend_vreg_wr_map_o = w_pend;

    // Counters widen internally so a set and several clears resolve before clamping at zero.
    always_comb begin
        for (int v = 0; v < VADDR_CNT; v++) begin
            w_sum[v] = SUM_W'(r_cnt[v]) + SUM_W'(w_issue & r_wr[v]);
            w_clr[v] = '0;
            for (int p = 0; p < PIPE_CNT; p++)
                w_clr[v] = w_clr[v] + SUM_W'(pend_vreg_wr_clear_i[p][v]);
            w_cnt_d[v] = (w_sum[v] > w_clr[v]) ? CNT_W'(w_sum[v] - w_clr[v]) : '0;
        end
    end

    always_ff @(posedge clk_i or negedge async_rst_ni) begin
        if (!async_rst_ni) begin
            r_hold_valid <= 1'b0;
            r_data       <= '0;
            r_wr         <= '0;
            r_rd         <= '0;
            r_cnt        <= '0;
            r_rr_ptr     <= '0;
            r_locked     <= 1'b0;
            r_sel        <= '0;
        end else begin
            if (instr_valid_i && instr_ready_o) begin
                r_hold_valid <= 1'b1;
                r_data       <= instr_data_i;
                r_wr         <= instr_vreg_wr_i;
                r_rd         <= instr_vreg_rd_i;
            end else if (w_issue) begin
                r_hold_valid <= 1'b0;
                r_data       <= '0;
                r_wr         <= '0;
                r_rd         <= '0;
            end
            r_locked <= w_go && !w_issue;
            r_sel    <= w_sel;
            if (w_issue)
                r_rr_ptr <= (w_sel == PTR_W'(PIPE_CNT - 1)) ? '0 : w_sel + 1'b1;
            r_cnt <= w_cnt_d;
        end
    end
endmodule
